// File: rtl/mixed_vec_checker.sv
// mixed_vec_checker: drives a fixed run of mixed-width lane vectors through a
// valid/ready handshake, checks each returned vector lane by lane against the
// expected pattern, and ends the run with sticky pass/fail status and a
// single-cycle finish pulse. Lane 0 occupies the LSBs of the packed bus.
module mixed_vec_checker #(
    parameter int NUM_LANES   = 4,
    parameter int BASE_WIDTH  = 8,
    parameter int WIDTH_STEP  = 4,
    parameter int NUM_VECTORS = 16,
    parameter int TIMEOUT     = 64,
    parameter int WARMUP      = 2,
    localparam int TOTAL_W    = NUM_LANES*BASE_WIDTH + WIDTH_STEP*NUM_LANES*(NUM_LANES-1)/2
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [TOTAL_W-1:0]   tx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [TOTAL_W-1:0]   rx_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timed_out,
    output logic [15:0]          err_count,
    output logic [NUM_LANES-1:0] fail_lane,
    output logic                 finish
);

    // Counter widths; the vector index must be able to hold NUM_VECTORS itself.
    localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS + 1) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WRM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int CNT_W = $clog2(NUM_LANES + 1);

    // Terminal values for each counter; WARMUP of 0 still spends one idle cycle
    // because the state register resets into the warmup state.
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [WRM_W-1:0] WARM_LAST = WRM_W'((WARMUP > 1) ? WARMUP - 1 : 0);

    typedef enum logic [1:0] {
        ST_WARMUP,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t               state;
    logic [WRM_W-1:0]     warm_cnt;
    logic [IDX_W-1:0]     vec_idx;
    logic [TMR_W-1:0]     timer;
    logic [TOTAL_W-1:0]   exp_vec;
    logic [NUM_LANES-1:0] lane_mismatch;
    logic [CNT_W-1:0]     mismatch_cnt;

    // Adds to the error counter, pinning at 0xFFFF instead of wrapping.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CNT_W-1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Per-lane expected value (2k + i + 1) truncated to the lane width, and the
    // lane-wise comparison of the returned vector against it.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int LW = BASE_WIDTH + i*WIDTH_STEP;
        localparam int LO = i*BASE_WIDTH + (WIDTH_STEP*i*(i-1))/2;
        logic [LW-1:0] lane_val;
        assign lane_val           = LW'({vec_idx, 1'b0}) + LW'(i + 1);
        assign exp_vec[LO +: LW]  = lane_val;
        assign lane_mismatch[i]   = (rx_data[LO +: LW] != lane_val);
    end

    // Number of lanes that disagree in the current response.
    always_comb begin
        mismatch_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            mismatch_cnt = mismatch_cnt + CNT_W'(lane_mismatch[i]);
        end
    end

    // The stimulus bus only carries the vector while it is offered.
    assign tx_data = tx_valid ? exp_vec : '0;

    // Pass is only meaningful once the run has ended.
    assign pass = done && (err_count == 16'd0) && !timed_out;

    // Sequencer: warmup, offer vector, await response, repeat until done or timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_WARMUP;
            warm_cnt  <= '0;
            vec_idx   <= '0;
            timer     <= '0;
            tx_valid  <= 1'b0;
            rx_ready  <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            timed_out <= 1'b0;
            err_count <= '0;
            fail_lane <= '0;
            finish    <= 1'b0;
        end else begin
            finish <= 1'b0;

            if (rx_valid && (state != ST_WAIT)) begin
                err_count <= sat_add(err_count, CNT_W'(1));
            end

            case (state)
                ST_WARMUP: begin
                    if (warm_cnt == WARM_LAST) begin
                        state    <= ST_SEND;
                        tx_valid <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end

                ST_SEND: begin
                    if (tx_ready) begin
                        state    <= ST_WAIT;
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b1;
                        timer    <= '0;
                    end
                end

                ST_WAIT: begin
                    if (rx_valid) begin
                        fail_lane <= fail_lane | lane_mismatch;
                        err_count <= sat_add(err_count, mismatch_cnt);
                        rx_ready  <= 1'b0;
                        vec_idx   <= vec_idx + 1'b1;
                        if (vec_idx == LAST_IDX) begin
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            finish <= 1'b1;
                        end else begin
                            state    <= ST_SEND;
                            tx_valid <= 1'b1;
                        end
                    end else if (timer == TMR_LAST) begin
                        state     <= ST_DONE;
                        rx_ready  <= 1'b0;
                        timed_out <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        finish    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_DONE;
                end

                default: begin
                    state <= ST_DONE;
                end
            endcase
        end
    end

endmodule
